tick_mem_loader: RTL

TICK_MEM_LOADER -- requirements
Module: tick_mem_loader

---
 rtl/tick_mem_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/tick_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tick_mem_loader
// Brief    : Streams host tick words into a ring of frame memories and keeps
//            them refilled as the timing core consumes them.
// Revision : 1.0
// ============================================================================
module tick_mem_loader #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 17,
    parameter int MAX_FRAMES = 5
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              start_i,
    input  logic [9:0]        points_per_line_i,
    input  logic [2:0]        number_of_frames_i,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              s_ready_o,
    input  logic              update_mem_i,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              we_o,
    output logic [2:0]        memory_selector_o,
    output logic              mem_updated_o,
    output logic              busy_o,
    output logic              cfg_err_o,
    output logic              overrun_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_INIT_FILL = 2'd1,
        S_READY     = 2'd2,
        S_REFILL    = 2'd3
    } state_t;

    localparam logic [31:0] c_max_frames = 32'(MAX_FRAMES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [9:0]        r_ppl;
    logic [2:0]        r_nframes;
    logic [9:0]        r_addr;
    logic [2:0]        r_sel;
    logic [2:0]        r_refill_sel;
    logic [2:0]        r_msel;
    logic              r_pending;
    logic              r_overrun;
    logic              r_upd_prev;
    logic              r_mem_updated;
    logic              r_cfg_err;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic       w_fill;
    logic       w_accept;
    logic       w_last_word;
    logic       w_wrap;
    logic       w_sel_last;
    logic       w_refill_last;
    logic       w_toggle;
    logic       w_cfg_ok;
    logic       w_start_ok;
    logic       w_start_bad;
    logic [2:0] w_target_sel;

    assign w_fill        = (r_state == S_INIT_FILL) || (r_state == S_REFILL);
    assign w_accept      = s_valid_i && w_fill;
    assign w_last_word   = (r_addr == (r_ppl - 10'd1));
    assign w_wrap        = w_accept && w_last_word;
    assign w_sel_last    = (r_sel == (r_nframes - 3'd1));
    assign w_refill_last = (r_refill_sel == (r_nframes - 3'd1));
    assign w_toggle      = update_mem_i ^ r_upd_prev;
    assign w_cfg_ok      = (number_of_frames_i != 3'd0)
                        && (32'(number_of_frames_i) <= c_max_frames)
                        && (points_per_line_i != 10'd0);
    assign w_start_ok    = (r_state == S_IDLE) && start_i && w_cfg_ok;
    assign w_start_bad   = (r_state == S_IDLE) && start_i && !w_cfg_ok;
    assign w_target_sel  = (r_state == S_REFILL) ? r_refill_sel : r_sel;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_start_ok) w_state_nxt = S_INIT_FILL;
            S_INIT_FILL: if (w_wrap && w_sel_last) w_state_nxt = S_READY;
            S_READY:     if (r_pending || w_toggle) w_state_nxt = S_REFILL;
            S_REFILL:    if (w_wrap) w_state_nxt = S_READY;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_ppl         <= '0;
            r_nframes     <= '0;
            r_addr        <= '0;
            r_sel         <= '0;
            r_refill_sel  <= '0;
            r_msel        <= '0;
            r_pending     <= 1'b0;
            r_overrun     <= 1'b0;
            r_upd_prev    <= 1'b1;
            r_mem_updated <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_we          <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= '0;
        end else begin
            r_upd_prev <= update_mem_i;
            r_we       <= w_accept;
            r_cfg_err  <= w_start_bad;
            // Selector is captured with each word so it stays aligned with the delayed write
            if (w_accept) begin
                r_waddr <= ADDR_W'(r_addr);
                r_wdata <= s_data_i;
                r_msel  <= w_target_sel;
                r_addr  <= w_last_word ? 10'd0 : r_addr + 10'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_ppl         <= points_per_line_i;
                        r_nframes     <= number_of_frames_i;
                        r_addr        <= '0;
                        r_sel         <= '0;
                        r_refill_sel  <= '0;
                        r_msel        <= '0;
                        r_pending     <= 1'b0;
                        r_overrun     <= 1'b0;
                        r_mem_updated <= 1'b0;
                    end
                end
                S_INIT_FILL: begin
                    if (w_wrap) begin
                        if (w_sel_last) begin
                            r_sel         <= '0;
                            r_mem_updated <= 1'b1;
                        end else begin
                            r_sel <= r_sel + 3'd1;
                        end
                    end
                end
                S_READY: begin
                    // A toggle arriving while a queued refill is launched becomes the next queued one
                    if (r_pending || w_toggle) begin
                        r_mem_updated <= 1'b0;
                        r_msel        <= r_refill_sel;
                        r_pending     <= r_pending && w_toggle;
                    end
                end
                S_REFILL: begin
                    if (w_toggle) begin
                        if (r_pending) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_pending <= 1'b1;
                        end
                    end
                    if (w_wrap) begin
                        r_mem_updated <= 1'b1;
                        r_refill_sel  <= w_refill_last ? 3'd0 : r_refill_sel + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_ready_o         = w_fill;
    assign busy_o            = w_fill;
    assign we_o              = r_we;
    assign waddr_o           = r_waddr;
    assign wdata_o           = r_wdata;
    assign memory_selector_o = r_msel;
    assign mem_updated_o     = r_mem_updated;
    assign cfg_err_o         = r_cfg_err;
    assign overrun_o         = r_overrun;

endmodule
`default_nettype wire
